// File: rtl/draw_paddles.sv
// Two-paddle overlay stage: paints left/right rackets over the incoming pixel stream with a
// fixed 2-cycle latency, latching positions and advancing hit-flash counters once per frame.
module draw_paddles #(
  parameter int PAD_W        = 10,
  parameter int PAD_LEN      = 80,
  parameter int XPOS_L       = 50,
  parameter int XPOS_R       = 963,
  parameter int SCREEN_H     = 768,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] y_pos_l,
  input  logic [10:0] y_pos_r,
  input  logic [11:0] color,
  input  logic [11:0] flash_color,
  input  logic        hit_l,
  input  logic        hit_r,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] Y_MAX = 12'(SCREEN_H - PAD_LEN);

  function automatic logic [10:0] clamp_y(input logic [10:0] y);
    return ({1'b0, y} > Y_MAX) ? Y_MAX[10:0] : y;
  endfunction

  // 12-bit compare so base+len never wraps near the bottom of the screen.
  function automatic logic in_span(input logic [11:0] v, input logic [11:0] base,
                                   input logic [11:0] len);
    return (v >= base) && (v < base + len);
  endfunction

  function automatic logic [7:0] next_cnt(input logic hit, input logic fe, input logic [7:0] cnt);
    if (hit) return 8'(FLASH_FRAMES);
    if (fe && cnt != 8'd0) return cnt - 8'd1;
    return cnt;
  endfunction

  function automatic logic [11:0] paint(input logic blank, input logic in_l, input logic in_r,
                                        input logic fl_l, input logic fl_r, input logic [11:0] bg,
                                        input logic [11:0] col, input logic [11:0] fcol);
    if (blank) return bg;
    if (in_l)  return fl_l ? fcol : col;
    if (in_r)  return fl_r ? fcol : col;
    return bg;
  endfunction

  logic        vblnk_d_q;
  logic [10:0] y_l_q, y_r_q, y_l_d, y_r_d;
  logic [7:0]  cnt_l_q, cnt_r_q, cnt_l_d, cnt_r_d;
  logic        fe, in_l_d, in_r_d;

  logic [10:0] hcount_p1_q, vcount_p1_q;
  logic        hsync_p1_q, vsync_p1_q, hblnk_p1_q, vblnk_p1_q;
  logic [11:0] rgb_p1_q;
  logic        in_l_p1_q, in_r_p1_q, flash_l_p1_q, flash_r_p1_q, blank_p1_q;

  logic [10:0] hcount_p2_q, vcount_p2_q;
  logic        hsync_p2_q, vsync_p2_q, hblnk_p2_q, vblnk_p2_q;
  logic [11:0] rgb_p2_q, rgb_p2_d;

  always_comb begin
    fe       = vblnk_in & ~vblnk_d_q;
    y_l_d    = fe ? clamp_y(y_pos_l) : y_l_q;
    y_r_d    = fe ? clamp_y(y_pos_r) : y_r_q;
    cnt_l_d  = next_cnt(hit_l, fe, cnt_l_q);
    cnt_r_d  = next_cnt(hit_r, fe, cnt_r_q);
    in_l_d   = in_span({1'b0, hcount_in}, 12'(XPOS_L), 12'(PAD_W)) &&
               in_span({1'b0, vcount_in}, {1'b0, y_l_q}, 12'(PAD_LEN));
    in_r_d   = in_span({1'b0, hcount_in}, 12'(XPOS_R), 12'(PAD_W)) &&
               in_span({1'b0, vcount_in}, {1'b0, y_r_q}, 12'(PAD_LEN));
    rgb_p2_d = paint(blank_p1_q, in_l_p1_q, in_r_p1_q, flash_l_p1_q, flash_r_p1_q,
                     rgb_p1_q, color, flash_color);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d_q    <= 1'b0;
      y_l_q        <= '0;
      y_r_q        <= '0;
      cnt_l_q      <= '0;
      cnt_r_q      <= '0;
      hcount_p1_q  <= '0;
      vcount_p1_q  <= '0;
      hsync_p1_q   <= 1'b0;
      vsync_p1_q   <= 1'b0;
      hblnk_p1_q   <= 1'b0;
      vblnk_p1_q   <= 1'b0;
      rgb_p1_q     <= '0;
      in_l_p1_q    <= 1'b0;
      in_r_p1_q    <= 1'b0;
      flash_l_p1_q <= 1'b0;
      flash_r_p1_q <= 1'b0;
      blank_p1_q   <= 1'b0;
      hcount_p2_q  <= '0;
      vcount_p2_q  <= '0;
      hsync_p2_q   <= 1'b0;
      vsync_p2_q   <= 1'b0;
      hblnk_p2_q   <= 1'b0;
      vblnk_p2_q   <= 1'b0;
      rgb_p2_q     <= '0;
    end else begin
      vblnk_d_q    <= vblnk_in;
      y_l_q        <= y_l_d;
      y_r_q        <= y_r_d;
      cnt_l_q      <= cnt_l_d;
      cnt_r_q      <= cnt_r_d;
      // Stage 1: hit tests against the frame-latched positions
      hcount_p1_q  <= hcount_in;
      vcount_p1_q  <= vcount_in;
      hsync_p1_q   <= hsync_in;
      vsync_p1_q   <= vsync_in;
      hblnk_p1_q   <= hblnk_in;
      vblnk_p1_q   <= vblnk_in;
      rgb_p1_q     <= rgb_in;
      in_l_p1_q    <= in_l_d;
      in_r_p1_q    <= in_r_d;
      flash_l_p1_q <= (cnt_l_q != 8'd0);
      flash_r_p1_q <= (cnt_r_q != 8'd0);
      blank_p1_q   <= hblnk_in | vblnk_in;
      // Stage 2: colour select, colours taken live
      hcount_p2_q  <= hcount_p1_q;
      vcount_p2_q  <= vcount_p1_q;
      hsync_p2_q   <= hsync_p1_q;
      vsync_p2_q   <= vsync_p1_q;
      hblnk_p2_q   <= hblnk_p1_q;
      vblnk_p2_q   <= vblnk_p1_q;
      rgb_p2_q     <= rgb_p2_d;
    end
  end

  assign hcount_out = hcount_p2_q;
  assign vcount_out = vcount_p2_q;
  assign hsync_out  = hsync_p2_q;
  assign vsync_out  = vsync_p2_q;
  assign hblnk_out  = hblnk_p2_q;
  assign vblnk_out  = vblnk_p2_q;
  assign rgb_out    = rgb_p2_q;

endmodule

// File: tb/tb_draw_paddles.sv
// Bench for draw_paddles: table of directed pixels plus hand sequences for frame latching,
// flash timing and reset; expected outputs are queued at drive time and checked 2 cycles later.
module tb_draw_paddles;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst, hs, vs, hb, vb, hl, hr;
  logic [10:0] hc, vc, ypl, ypr;
  logic [11:0] rgb, col, fcol;

  logic [10:0] o_hc, o_vc, o2_hc, o2_vc;
  logic        o_hs, o_vs, o_hb, o_vb, o2_hs, o2_vs, o2_hb, o2_vb;
  logic [11:0] o_rgb, o2_rgb;

  draw_paddles dut (
    .pclk(pclk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .hsync_in(hs), .vsync_in(vs),
    .hblnk_in(hb), .vblnk_in(vb), .rgb_in(rgb), .y_pos_l(ypl), .y_pos_r(ypr), .color(col),
    .flash_color(fcol), .hit_l(hl), .hit_r(hr), .hcount_out(o_hc), .vcount_out(o_vc),
    .hsync_out(o_hs), .vsync_out(o_vs), .hblnk_out(o_hb), .vblnk_out(o_vb), .rgb_out(o_rgb)
  );

  // Second instance with both paddles in the same columns to exercise overlap priority.
  draw_paddles #(.XPOS_R(50)) dut2 (
    .pclk(pclk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .hsync_in(hs), .vsync_in(vs),
    .hblnk_in(hb), .vblnk_in(vb), .rgb_in(rgb), .y_pos_l(ypl), .y_pos_r(ypr), .color(col),
    .flash_color(fcol), .hit_l(hl), .hit_r(hr), .hcount_out(o2_hc), .vcount_out(o2_vc),
    .hsync_out(o2_hs), .vsync_out(o2_vs), .hblnk_out(o2_hb), .vblnk_out(o2_vb), .rgb_out(o2_rgb)
  );

  // k / k2: 0 = rgb_in passes, 1 = paddle colour, 2 = flash colour; k2 = -1 leaves dut2 unchecked.
  typedef struct {
    int          k;
    int          k2;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    string       tag;
  } exp_t;

  typedef struct {
    logic [10:0] h, v;
    logic        hb;
    int          k;
    string       tag;
  } vec_t;

  exp_t  q[$];
  exp_t  zero_e;
  string tag;
  int    errors = 0;
  int    checks = 0;

  function automatic logic [11:0] pick(input int k, input logic [11:0] bg);
    return (k == 1) ? col : (k == 2) ? fcol : bg;
  endfunction

  task automatic cmp(input exp_t e);
    logic [11:0] er;
    er = pick(e.k, e.rgb);
    checks++;
    if ({o_hc, o_vc, o_hs, o_vs, o_hb, o_vb, o_rgb} !== {e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, er}) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs/vs=%b%b hb/vb=%b%b rgb=%h, want h=%0d v=%0d hs/vs=%b%b hb/vb=%b%b rgb=%h",
               e.tag, o_hc, o_vc, o_hs, o_vs, o_hb, o_vb, o_rgb,
               e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, er);
    end
    if (e.k2 >= 0) begin
      er = pick(e.k2, e.rgb);
      checks++;
      if ({o2_hc, o2_vc, o2_hs, o2_vs, o2_hb, o2_vb, o2_rgb} !== {e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, er}) begin
        errors++;
        $display("FAIL %s(overlap dut): got h=%0d v=%0d rgb=%h, want h=%0d v=%0d rgb=%h",
                 e.tag, o2_hc, o2_vc, o2_rgb, e.hc, e.vc, er);
      end
    end
  endtask

  task automatic step(input int k, input int k2);
    exp_t e;
    e.k = k; e.k2 = k2; e.hc = hc; e.vc = vc; e.hs = hs; e.vs = vs;
    e.hb = hb; e.vb = vb; e.rgb = rgb; e.tag = tag;
    if (!rst) q.push_back(e);
    @(posedge pclk);
    #1;
    if (rst) begin
      q.delete();
      zero_e.tag = tag;
      q.push_back(zero_e);
      cmp(zero_e);
    end else if (q.size() >= 2) begin
      cmp(q.pop_front());
    end
    @(negedge pclk);
    hl = 1'b0;
    hr = 1'b0;
  endtask

  task automatic pix(input int h, input int v, input int k, input int k2 = -1, input logic hbl = 1'b0);
    hc = 11'(h); vc = 11'(v); hb = hbl; vb = 1'b0;
    hs = 1'($urandom); vs = 1'($urandom); rgb = 12'($urandom);
    step(k, k2);
  endtask

  // Low-high-low on vblnk; the rising cycle is the frame edge and may carry a hit.
  task automatic frame_edge(input logic hit);
    pix(0, 0, 0);
    hc = 11'd0; vc = 11'd0; hb = 1'b0; vb = 1'b1; rgb = 12'($urandom); hl = hit;
    step(0, -1);
    pix(0, 0, 0);
  endtask

  vec_t tbl[14];

  initial begin
    zero_e = '{k: 0, k2: 0, hc: '0, vc: '0, hs: 0, vs: 0, hb: 0, vb: 0, rgb: '0, tag: ""};
    tbl[0]  = '{h: 55,  v: 100, hb: 0, k: 1, tag: "left top line"};
    tbl[1]  = '{h: 60,  v: 100, hb: 0, k: 0, tag: "left right edge excl"};
    tbl[2]  = '{h: 55,  v: 180, hb: 0, k: 0, tag: "left bottom excl"};
    tbl[3]  = '{h: 55,  v: 179, hb: 0, k: 1, tag: "left bottom line"};
    tbl[4]  = '{h: 50,  v: 150, hb: 0, k: 1, tag: "left first column"};
    tbl[5]  = '{h: 49,  v: 150, hb: 0, k: 0, tag: "left col before"};
    tbl[6]  = '{h: 55,  v: 99,  hb: 0, k: 0, tag: "left line above"};
    tbl[7]  = '{h: 963, v: 688, hb: 0, k: 1, tag: "right clamped top"};
    tbl[8]  = '{h: 963, v: 687, hb: 0, k: 0, tag: "right above clamp"};
    tbl[9]  = '{h: 963, v: 767, hb: 0, k: 1, tag: "right last line"};
    tbl[10] = '{h: 972, v: 767, hb: 0, k: 1, tag: "right last column"};
    tbl[11] = '{h: 973, v: 767, hb: 0, k: 0, tag: "right past column"};
    tbl[12] = '{h: 55,  v: 100, hb: 1, k: 0, tag: "left under hblnk"};
    tbl[13] = '{h: 500, v: 400, hb: 0, k: 0, tag: "background"};

    col = 12'hF00; fcol = 12'h0FF; ypl = 11'd0; ypr = 11'd0;
    hl = 1'b0; hr = 1'b0; hb = 1'b0; vb = 1'b0;

    tag = "reset";
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hc = 11'($urandom); vc = 11'($urandom); hs = 1'($urandom); vs = 1'($urandom);
      hb = 1'($urandom); vb = 1'($urandom); rgb = 12'($urandom);
      hl = 1'($urandom); hr = 1'($urandom); ypl = 11'($urandom); ypr = 11'($urandom);
      step(0, 0);
    end
    rst = 1'b0; hl = 1'b0; hr = 1'b0;
    tag = "after reset";
    for (int i = 0; i < 4; i++) pix($urandom_range(900, 100), $urandom_range(767, 0), 0, 0);

    ypl = 11'd100; ypr = 11'd2000;
    tag = "latch frame";
    frame_edge(1'b0);
    for (int i = 0; i < 14; i++) begin
      tag = tbl[i].tag;
      pix(tbl[i].h, tbl[i].v, tbl[i].k, -1, tbl[i].hb);
    end

    tag = "mid-frame move";
    ypl = 11'd300;
    pix(55, 100, 1);
    pix(55, 300, 0);
    frame_edge(1'b0);
    tag = "moved after edge";
    pix(55, 300, 1);
    pix(55, 100, 0);

    tag = "hit cycle";
    col = 12'h0A0; fcol = 12'hFF0;
    hl = 1'b1;
    pix(55, 300, 1);
    tag = "flash frame0";
    pix(55, 300, 2);
    for (int f = 1; f <= 8; f++) begin
      frame_edge(1'b0);
      tag = $sformatf("flash after edge %0d", f);
      pix(55, 300, (f < 8) ? 2 : 1);
    end

    tag = "reload hit";
    hl = 1'b1;
    pix(55, 300, 1);
    for (int f = 1; f <= 5; f++) frame_edge(1'b0);
    tag = "flash cnt3";
    pix(55, 300, 2);
    frame_edge(1'b1);
    tag = "hit on edge";
    pix(55, 300, 2);
    for (int f = 1; f <= 8; f++) begin
      frame_edge(1'b0);
      tag = $sformatf("edge-hit after edge %0d", f);
      pix(55, 300, (f < 8) ? 2 : 1);
    end

    tag = "pre-reset flash";
    hl = 1'b1;
    pix(55, 300, 1);
    pix(55, 300, 2);
    tag = "mid reset";
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    tag = "pos zero after reset";
    pix(55, 0, 1, 1);
    tag = "old pos after reset";
    pix(55, 300, 0, 0);

    tag = "overlap hit_r";
    hr = 1'b1;
    pix(55, 10, 1, 1);
    tag = "overlap left wins";
    pix(55, 10, 1, 1);
    tag = "right flashing";
    pix(963, 10, 2, 0);

    tag = "flush";
    pix(0, 0, 0);
    pix(0, 0, 0);
    pix(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
